// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: two-entry elastic buffer (main + skid) feeding register-file
// writeback, with flush, hazard-unit forwarding tap and a retired-instruction counter.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_aluresult,
    input  logic [DATA_W-1:0] in_memdata,
    input  logic [REG_AW-1:0] in_writereg,
    input  logic              in_regwrite,
    input  logic              in_memtoreg,
    input  logic              in_pcsrc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] out_writereg,
    output logic              out_pcsrc,
    output logic [DATA_W-1:0] wb_data,
    output logic              rf_we,
    output logic              fwd_valid,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retired
);

    typedef struct packed {
        logic [DATA_W-1:0] aluresult;
        logic [DATA_W-1:0] memdata;
        logic [REG_AW-1:0] writereg;
        logic              regwrite;
        logic              memtoreg;
        logic              pcsrc;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    entry_t             main_q, main_d;
    entry_t             skid_q, skid_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    entry_t             in_entry;
    logic               accept, consume;

    assign in_entry = '{aluresult: in_aluresult, memdata: in_memdata, writereg: in_writereg,
                        regwrite: in_regwrite, memtoreg: in_memtoreg, pcsrc: in_pcsrc};

    // Both handshakes derive only from registered state, so in_ready never sees out_ready.
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != TWO);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    always_comb begin
        state_d   = state_q;
        main_d    = main_q;
        skid_d    = skid_q;
        retired_d = retired_q + CNT_W'(consume);
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = in_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    main_d = in_entry;
                end else if (accept) begin
                    skid_d  = in_entry;
                    state_d = TWO;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (consume) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush drops the valid bits only; a same-cycle consume has already been counted.
        if (flush) state_d = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            retired_q <= retired_d;
        end
    end

    assign out_writereg = main_q.writereg;
    assign out_pcsrc    = main_q.pcsrc;
    assign wb_data      = main_q.memtoreg ? main_q.memdata : main_q.aluresult;
    assign fwd_data     = wb_data;
    assign fwd_valid    = out_valid & main_q.regwrite & (main_q.writereg != '0);
    assign rf_we        = fwd_valid & out_ready;
    assign retired      = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a queue model predicts the outputs each cycle,
// and literal checks pin the model at the points called out in the test plan.
module tb_mem_wb_stage;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, in_ready;
    logic [DATA_W-1:0] in_aluresult, in_memdata;
    logic [REG_AW-1:0] in_writereg;
    logic              in_regwrite, in_memtoreg, in_pcsrc;
    logic              out_valid, out_ready;
    logic [REG_AW-1:0] out_writereg;
    logic              out_pcsrc;
    logic [DATA_W-1:0] wb_data, fwd_data;
    logic              rf_we, fwd_valid;
    logic [CNT_W-1:0]  retired;

    mem_wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_aluresult(in_aluresult), .in_memdata(in_memdata), .in_writereg(in_writereg),
        .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_pcsrc(in_pcsrc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_writereg(out_writereg), .out_pcsrc(out_pcsrc),
        .wb_data(wb_data), .rf_we(rf_we), .fwd_valid(fwd_valid), .fwd_data(fwd_data),
        .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] mem;
        logic [REG_AW-1:0] wr;
        logic              rw;
        logic              m2r;
        logic              pc;
    } ent_t;

    ent_t q[$];
    int   m_cnt;
    bit   m_zero;   // main data regs still hold their reset value
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO of depth 2, ready when fewer than two entries held.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_cnt  = 0;
            m_zero = 1'b1;
        end else begin
            bit acc, cons;
            acc  = in_valid && (q.size() < 2);
            cons = (q.size() > 0) && out_ready;
            if (acc) m_zero = 1'b0;
            if (cons) begin
                void'(q.pop_front());
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end
            if (flush) q.delete();
            else if (acc) q.push_back('{in_aluresult, in_memdata, in_writereg,
                                        in_regwrite, in_memtoreg, in_pcsrc});
        end
    end

    always @(negedge clk) begin
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready",  64'(in_ready),  64'(q.size() < 2));
        chk("retired",   64'(retired),   64'(m_cnt));
        if (q.size() > 0) begin
            logic [DATA_W-1:0] d;
            logic              fv;
            d  = q[0].m2r ? q[0].mem : q[0].alu;
            fv = q[0].rw && (q[0].wr != 0);
            chk("wb_data",      64'(wb_data),      64'(d));
            chk("fwd_data",     64'(fwd_data),     64'(d));
            chk("out_writereg", 64'(out_writereg), 64'(q[0].wr));
            chk("out_pcsrc",    64'(out_pcsrc),    64'(q[0].pc));
            chk("fwd_valid",    64'(fwd_valid),    64'(fv));
            chk("rf_we",        64'(rf_we),        64'(fv && out_ready));
        end else begin
            chk("fwd_valid_idle", 64'(fwd_valid), 64'd0);
            chk("rf_we_idle",     64'(rf_we),     64'd0);
            if (m_zero) begin
                chk("wb_data_rst",  64'(wb_data),      64'd0);
                chk("writereg_rst", 64'(out_writereg), 64'd0);
                chk("pcsrc_rst",    64'(out_pcsrc),    64'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem,
                         input logic [REG_AW-1:0] wr, input logic rw, input logic m2r, input logic pc);
        in_valid     = v;
        in_aluresult = alu;
        in_memdata   = mem;
        in_writereg  = wr;
        in_regwrite  = rw;
        in_memtoreg  = m2r;
        in_pcsrc     = pc;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        step(); step();
        rst = 1'b0;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset in_ready",  64'(in_ready),  64'd1);
        chk("reset retired",   64'(retired),   64'd0);

        // Stream: four back-to-back entries with the sink always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h10 + 32'(i), 32'hA000_0000 + 32'(i), 5'(i + 1), 1'b1, 1'b0, 1'(i));
            step();
            if (i == 0) begin
                chk("stream first wb_data", 64'(wb_data), 64'h10);
                chk("stream first rf_we",   64'(rf_we),   64'd1);
            end
        end
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        step();
        chk("stream retired", 64'(retired), 64'd4);
        step();

        // Backpressure: fill both slots, hold C at the source, then drain.
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1); step();
        drive(1'b1, 32'hB, 32'h0, 5'd8, 1'b0, 1'b0, 1'b0); step();
        chk("bp full in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 32'hC, 32'hCC, 5'd9, 1'b1, 1'b1, 1'b0); step();
        step();
        chk("bp hold wb_data", 64'(wb_data), 64'hA);
        out_ready = 1'b1;
        step();
        chk("bp second wb_data", 64'(wb_data), 64'hB);
        step();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("bp third wb_data", 64'(wb_data), 64'hCC);
        step();
        chk("bp retired", 64'(retired), 64'd7);

        // Load data selected; register 0 is never written.
        drive(1'b1, 32'h5, 32'hDEADBEEF, 5'd0, 1'b1, 1'b1, 1'b0); step();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("r0 wb_data",   64'(wb_data),   64'hDEADBEEF);
        chk("r0 rf_we",     64'(rf_we),     64'd0);
        chk("r0 fwd_valid", 64'(fwd_valid), 64'd0);
        step();

        // Flush while full with a new entry offered; the consume at that edge still retires.
        out_ready = 1'b0;
        drive(1'b1, 32'hD, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 32'hE, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 32'hF, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("flush out_valid", 64'(out_valid), 64'd0);
        chk("flush in_ready",  64'(in_ready),  64'd1);
        chk("flush retired",   64'(retired),   64'd9);
        step(); step();

        // Counter wrap: 17 consumes from reset on a 4-bit counter.
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 32'h0, 5'(i % 31 + 1), 1'b1, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        step();
        chk("wrap retired", 64'(retired), 64'd1);

        // Reset in the middle of a stalled stream.
        out_ready = 1'b0;
        drive(1'b1, 32'h77, 32'h88, 5'd6, 1'b1, 1'b1, 1'b1); step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("mid rst out_valid", 64'(out_valid), 64'd0);
        chk("mid rst in_ready",  64'(in_ready),  64'd1);
        chk("mid rst retired",   64'(retired),   64'd0);
        chk("mid rst wb_data",   64'(wb_data),   64'd0);
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Parametrised MEM/WB pipeline stage for the MIPS core: an elastic two-entry register between the memory stage and register-file writeback. It carries the ALU result, load data, destination register and control bits, and produces the writeback data and a gated register-file write enable. It supports backpressure (valid/ready with skid), flush, a forwarding tap for the hazard unit, and a retired-instruction counter.

## Interface
- DATA_W, 32, width of ALU result, load data and writeback data
- REG_AW, 5, register-address width
- CNT_W, 32, retire-counter width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all held and incoming entries this cycle
- in_valid  in  1  MEM stage presents an entry
- in_ready  out  1  stage can accept an entry
- in_aluresult  in  DATA_W  ALU result from MEM
- in_memdata  in  DATA_W  load data from data memory
- in_writereg  in  REG_AW  destination register
- in_regwrite  in  1  entry writes the register file
- in_memtoreg  in  1  1 = write load data, 0 = write ALU result
- in_pcsrc  in  1  branch-taken flag carried to WB
- out_valid  out  1  WB entry valid
- out_ready  in  1  WB consumes the entry
- out_writereg  out  REG_AW  held destination
- out_pcsrc  out  1  held branch flag
- wb_data  out  DATA_W  out_memtoreg ? held memdata : held aluresult
- rf_we  out  1  out_valid & out_ready & regwrite & (out_writereg != 0)
- fwd_valid  out  1  out_valid & regwrite & (out_writereg != 0)
- fwd_data  out  DATA_W  equals wb_data
- retired  out  CNT_W  count of consumed entries

## Operation
- Storage: main register (drives outputs) plus one skid register; each has a valid bit.
- States: EMPTY (main invalid), ONE (main valid, skid invalid), TWO (both valid). Skid is never valid while main is invalid.
- in_ready = ~skid_valid, a pure register output with no combinational path from out_ready.
- Accept = in_valid & in_ready; consume = out_valid & out_ready.
- EMPTY: accept -> ONE, entry loads into main.
- ONE: accept & consume -> ONE, new entry loads into main. Accept & ~consume -> TWO, entry loads into skid. ~accept & consume -> EMPTY. Neither -> hold.
- TWO (in_ready=0): consume -> ONE, skid moves into main. Otherwise hold.
- Order is preserved; no entry is duplicated or dropped except on flush.
- flush (priority over all else): both valid bits clear next cycle; an accept in the same cycle is discarded; a consume in the same cycle still counts as retired. Data registers need not clear.
- retired increments by 1 on each consume and wraps modulo 2^CNT_W. flush does not reset it.
- Register 0 is never written: rf_we and fwd_valid are forced low when out_writereg = 0.

## Timing
- Reset: out_valid=0, skid_valid=0, retired=0, all data and control registers 0; hence wb_data=0, rf_we=0, fwd_valid=0. in_ready=1 from the first cycle after reset is released.
- rst asserted mid-operation discards all entries at the next edge, same as flush plus counter clear.
- Latency: an entry accepted at edge N appears on the outputs after edge N (visible in cycle N+1).
- Throughput: 1 entry/cycle while out_ready=1.
- in_ready falls the cycle after a stall fills skid and rises the cycle after the consume that drains it.
- wb_data, rf_we and fwd_* are combinational from held state and out_ready only.

## Test plan
- Stream: out_ready=1, 4 entries back-to-back (alu 0x10..0x13, memtoreg=0, writereg 1..4) -> outputs appear 1 cycle later in order, rf_we high each cycle, retired=4.
- Backpressure: out_ready=0 while 2 entries are sent -> TWO, in_ready=0, third entry held by source. Then out_ready=1 for 3 cycles -> entries in order A,B,C; none lost.
- memtoreg/r0: entry memdata=0xDEADBEEF, alu=0x5, memtoreg=1, writereg=0 -> wb_data=0xDEADBEEF, rf_we=0, fwd_valid=0.
- Flush in TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed and incoming entries never appear.
- Counter wrap: CNT_W=4, 17 consumes -> retired=1. rst mid-stream -> all outputs at reset values next cycle.
